// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// fetched from an external key-schedule store through rk_idx/rk_in.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Products {0e, 0b, 0d, 09} * a packed MSB-first, built from one xtime chain.
    function automatic logic [31:0] mul_ebd9(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0]  m [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                m[i] = mul_ebd9(s[127 - 8 * (4 * c + i) -: 8]);
            end
            // Field order in m[i]: [31:24]=0e, [23:16]=0b, [15:8]=0d, [7:0]=09
            o[127 - 32 * c -: 8]      = m[0][31:24] ^ m[1][23:16] ^ m[2][15:8]  ^ m[3][7:0];
            o[127 - 32 * c - 8 -: 8]  = m[0][7:0]   ^ m[1][31:24] ^ m[2][23:16] ^ m[3][15:8];
            o[127 - 32 * c - 16 -: 8] = m[0][15:8]  ^ m[1][7:0]   ^ m[2][31:24] ^ m[3][23:16];
            o[127 - 32 * c - 24 -: 8] = m[0][23:16] ^ m[1][15:8]  ^ m[2][7:0]   ^ m[3][31:24];
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] round_core;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        blk_d      = blk_q;
        pt_d       = pt_q;
        round_core = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_in;
        case (state_q)
            IDLE: begin
                if (start) begin
                    blk_d   = ct_in ^ rk_in;
                    round_d = 4'(NR - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (round_q == 4'd0) begin
                    pt_d    = round_core;
                    state_d = DONE;
                end else begin
                    blk_d   = inv_mix_columns(round_core);
                    round_d = round_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Key index is registered so the external store sees a glitch-free address.
        rk_idx_d = (state_d == RUN) ? round_d : 4'(NR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            round_q  <= '0;
            rk_idx_q <= 4'(NR);
            blk_q    <= '0;
            pt_q     <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            rk_idx_q <= rk_idx_d;
            blk_q    <= blk_d;
            pt_q     <= pt_d;
        end
    end

    assign rk_idx = rk_idx_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign pt_out = pt_q;

endmodule
